led_flow_dir_chaser: RTL
========================

// Module: led_flow_dir_chaser
// PURPOSE
//  One-hot LED chaser with run-time direction control and a step prescaler.
//  dir=0 runs forward (LED1->LED2->...->LEDN->LED1); dir=1 runs reverse.
//  Drives the board LED bank directly and gives step/wrap pulses to other logic.
//  Sits beside the fixed-direction flow blocks in the LED demo top level.
// PARAMETERS
//  N_LED  3  number of LEDs, legal range >= 2
//  DIV    4  enabled clk cycles per step, legal range >= 1
// PORTS
//  clk       in   1      clock; all state updates on posedge
//  rst       in   1      asynchronous active-low reset
//  en        in   1      1 = run, 0 = freeze prescaler and position
//  dir       in   1      0 = forward (index up), 1 = reverse (index down)
//  LED_Show  out  N_LED  one-hot LED drive, bit0 = LED1; registered
//  step      out  1      one-cycle pulse on the edge where LED_Show changes
//  wrap      out  1      one-cycle pulse when position wraps or bounces at an end
// BEHAVIOUR
//  - Reset (rst=0, async): pos=0, prescaler=0, LED_Show=1 (LED1), step=0, wrap=0.
//    Reset applies immediately mid-step. The first step after release occurs
//    DIV enabled cycles later.
//  - Prescaler cnt counts 0..DIV-1 on each clk with en=1. en=0: cnt, pos and
//    LED_Show hold, and step/wrap are 0.
//  - Step event: en=1 and cnt==DIV-1. cnt goes to 0 and pos advances on the same edge.
//    LED_Show=1<<pos_next and step=1 for exactly that cycle. LED_Show is never 0
//    and never multi-hot.
//  - DIV=1: every enabled cycle is a step.
//  - Direction: dir is sampled only on the step edge. Toggling dir between steps
//    has no effect until the next step. No extra latency on reversal.
//  - Forward: pos_next = (pos==N_LED-1) ? 0 : pos+1; wrap=1 when pos goes N_LED-1->0.
//  - Reverse: pos_next = (pos==0) ? N_LED-1 : pos-1; wrap=1 when pos goes 0->N_LED-1.
//  - step and wrap are registered outputs. wrap asserts only together with step.
//  - Illegal pos (>= N_LED, reachable only by upset): the next step forces pos=0,
//    with wrap=1 in both directions.
//  - en falling on the step cycle: the step still completes on that edge and
//    further stepping freezes.
// CONFIGURATION
//  LED_BOUNCE_EN defined: ping-pong mode.
//   - dir input is ignored. An internal direction bit resets to forward.
//   - At pos==N_LED-1 going forward, the direction bit flips and pos goes to N_LED-2.
//     At pos==0 going reverse, it flips and pos goes to 1.
//   - wrap=1 on each bounce step. Sequence for N_LED=3: 0,1,2,1,0,1,...
//  LED_BOUNCE_EN undefined: wrap-around mode as described in BEHAVIOUR; dir is honoured.
// TESTING
//  - Reset: rst=0 held 3 cycles, then released -> LED_Show=001, step=0, wrap=0.
//    First step after 4 clks gives LED_Show=010.
//  - Forward wrap: N_LED=3, DIV=4, dir=0, en=1 for 12 clks -> LED_Show 010,100,001
//    at clks 4,8,12. wrap=1 only at clk 12.
//  - Reverse mid-run: after LED_Show=010, set dir=1 at cnt=1 -> next step gives 001,
//    then 100 with wrap=1, then 010.
//  - Hold: en=0 for 10 clks at cnt=2 -> LED_Show, step and wrap frozen/0.
//    After en=1, the step occurs after 2 more clks.
//  - Async reset mid-step: assert rst=0 between edges while LED_Show=100 ->
//    LED_Show=001 immediately, with no clk edge needed.
//  - LED_BOUNCE_EN, DIV=1, N_LED=3: 8 enabled clks -> 010,100,010,001,010,100,010,001.
//    wrap=1 on each 100 and 001 step.

Source files
------------

// File: rtl/led_flow_dir_chaser.sv
// One-hot LED chaser with run-time direction and a step prescaler.
// Define LED_BOUNCE_EN for ping-pong mode (dir ignored, reverses at each end).
module led_flow_dir_chaser #(
    parameter int N_LED = 3,
    parameter int DIV   = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             dir,
    output logic [N_LED-1:0] LED_Show,
    output logic             step,
    output logic             wrap
);

    localparam int PW = $clog2(N_LED);
    localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [PW-1:0]    LAST     = PW'(N_LED - 1);
    localparam logic [CW-1:0]    CNT_LAST = CW'(DIV - 1);
    localparam logic [N_LED-1:0] LED_ONE  = N_LED'(1);

    logic [CW-1:0]    cnt_q, cnt_d;
    logic [PW-1:0]    pos_q, pos_d;
    logic [N_LED-1:0] led_q, led_d;
    logic             step_q, step_d;
    logic             wrap_q, wrap_d;

`ifdef LED_BOUNCE_EN
    // Internal travel direction: 0 = toward LEDN, 1 = toward LED1.
    logic bdir_q, bdir_d;
    logic unused_dir;
    assign unused_dir = dir;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) bdir_q <= 1'b0;
        else      bdir_q <= bdir_d;
    end
`endif

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_q  <= '0;
            pos_q  <= '0;
            led_q  <= LED_ONE;
            step_q <= 1'b0;
            wrap_q <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            pos_q  <= pos_d;
            led_q  <= led_d;
            step_q <= step_d;
            wrap_q <= wrap_d;
        end
    end

    always_comb begin
        cnt_d  = cnt_q;
        pos_d  = pos_q;
        led_d  = led_q;
        step_d = 1'b0;
        wrap_d = 1'b0;
`ifdef LED_BOUNCE_EN
        bdir_d = bdir_q;
`endif
        if (en) begin
            if (cnt_q == CNT_LAST) begin
                cnt_d  = '0;
                step_d = 1'b1;
                // An out-of-range position can only come from an upset; recover to LED1.
                if (pos_q > LAST) begin
                    pos_d  = '0;
                    wrap_d = 1'b1;
`ifdef LED_BOUNCE_EN
                    bdir_d = 1'b0;
`endif
                end
`ifdef LED_BOUNCE_EN
                else begin
                    if (!bdir_q) begin
                        if (pos_q == LAST) begin
                            pos_d  = LAST - PW'(1);
                            bdir_d = 1'b1;
                        end else begin
                            pos_d = pos_q + PW'(1);
                        end
                    end else begin
                        if (pos_q == '0) begin
                            pos_d  = PW'(1);
                            bdir_d = 1'b0;
                        end else begin
                            pos_d = pos_q - PW'(1);
                        end
                    end
                    // Flag the step that lands on either end of the bank.
                    wrap_d = (pos_d == LAST) || (pos_d == '0);
                end
`else
                else if (!dir) begin
                    if (pos_q == LAST) begin
                        pos_d  = '0;
                        wrap_d = 1'b1;
                    end else begin
                        pos_d = pos_q + PW'(1);
                    end
                end else begin
                    if (pos_q == '0) begin
                        pos_d  = LAST;
                        wrap_d = 1'b1;
                    end else begin
                        pos_d = pos_q - PW'(1);
                    end
                end
`endif
                led_d = LED_ONE << pos_d;
            end else begin
                cnt_d = cnt_q + CW'(1);
            end
        end
    end

    assign LED_Show = led_q;
    assign step     = step_q;
    assign wrap     = wrap_q;

endmodule
